// File: rtl/probe_train_gen.sv
// Probe-train transmitter: injects sequence-numbered, timestamped probe packets between upstream packets.
// Optional abort input enabled by defining PROBE_TRAIN_GEN_ABORT_EN.
module probe_train_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int PKT_WORDS  = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  cfg_start,
  input  logic [15:0]           cfg_num_pkts,
  input  logic [15:0]           cfg_gap,
  input  logic [7:0]            cfg_dst_port,
  input  logic [31:0]           cfg_dst_ip,
`ifdef PROBE_TRAIN_GEN_ABORT_EN
  input  logic                  cfg_abort,
`endif
  output logic                  busy,
  output logic [15:0]           sent_count,
  output logic [TS_WIDTH-1:0]   ts_last
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_BOUND = 3'd1,
    ST_HDR        = 3'd2,
    ST_BODY       = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  localparam logic [7:0]  LAST_IDX  = 8'(PKT_WORDS - 1);
  localparam logic [15:0] LEN_WORDS = 16'(PKT_WORDS - 1);
  localparam logic [15:0] LEN_BYTES = 16'((PKT_WORDS - 1) * 8);

  state_t                state_r, state_nxt_s;
  logic                  in_pkt_r;
  logic [TS_WIDTH-1:0]   ts_r, ts_last_r;
  logic [15:0]           gap_cnt_r, seq_r, sent_count_r;
  logic [15:0]           num_pkts_r, gap_r;
  logic [7:0]            dst_port_r, idx_r;
  logic [31:0]           dst_ip_r;
  logic                  busy_r, abort_pend_r;

  logic                  own_s, acc_pt_s, acc_own_s, boundary_ok_s;
  logic                  start_s, last_word_s, train_done_s, gap_met_s, abort_s;
  logic [15:0]           gap_nxt_s;
  logic [63:0]           probe_word_s;
  logic [7:0]            probe_ctrl_s;

`ifdef PROBE_TRAIN_GEN_ABORT_EN
  assign abort_s = cfg_abort;
`else
  assign abort_s = 1'b0;
`endif

  assign own_s         = (state_r == ST_HDR) || (state_r == ST_BODY);
  assign acc_pt_s      = in_wr & out_rdy & ~own_s;
  assign acc_own_s     = own_s & out_rdy;
  // A header being accepted this cycle opens a packet even though the flag is still clear.
  assign boundary_ok_s = ~in_pkt_r & ~(acc_pt_s & (in_ctrl == CTRL_WIDTH'(8'hff)));
  assign start_s       = (state_r == ST_IDLE) & cfg_start & (cfg_num_pkts != 16'd0);
  assign last_word_s   = (state_r == ST_BODY) && (idx_r == LAST_IDX);
  assign train_done_s  = ((sent_count_r + 16'd1) == num_pkts_r) | abort_pend_r | abort_s;
  assign gap_nxt_s     = (gap_cnt_r == 16'hffff) ? 16'hffff : gap_cnt_r + 16'd1;
  assign gap_met_s     = gap_nxt_s >= gap_r;

  // Next-state logic for the train sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_WAIT_BOUND;
        else         state_nxt_s = ST_IDLE;
      end
      ST_WAIT_BOUND: begin
        if (abort_s)            state_nxt_s = ST_IDLE;
        else if (boundary_ok_s) state_nxt_s = ST_HDR;
        else                    state_nxt_s = ST_WAIT_BOUND;
      end
      ST_HDR: begin
        if (acc_own_s) state_nxt_s = ST_BODY;
        else           state_nxt_s = ST_HDR;
      end
      ST_BODY: begin
        if (acc_own_s && last_word_s) begin
          if (train_done_s)   state_nxt_s = ST_IDLE;
          else if (gap_met_s) state_nxt_s = ST_HDR;
          else                state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_BODY;
        end
      end
      ST_GAP: begin
        if (abort_s)                       state_nxt_s = ST_IDLE;
        else if (gap_met_s && boundary_ok_s) state_nxt_s = ST_HDR;
        else if (gap_met_s)                state_nxt_s = ST_WAIT_BOUND;
        else                               state_nxt_s = ST_GAP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Probe word content selected by state and word index.
  always_comb begin
    probe_word_s = 64'h0;
    probe_ctrl_s = 8'h00;
    if (state_r == ST_HDR) begin
      probe_word_s = {8'h00, dst_port_r, LEN_WORDS, 16'h0000, LEN_BYTES};
      probe_ctrl_s = 8'hff;
    end else if (idx_r == 8'd1) begin
      probe_word_s = {dst_ip_r, 16'h0800, seq_r};
    end else if (idx_r == 8'd2) begin
      probe_word_s = {32'h0, 16'h0000, 16'(ts_last_r)};
    end else begin
      probe_word_s = {seq_r, 16'h0000, 24'h000000, idx_r};
      if (idx_r == LAST_IDX) probe_ctrl_s = 8'h01;
      else                   probe_ctrl_s = 8'h00;
    end
  end

  // Bus mux: zero-latency pass-through unless a probe owns the bus.
  always_comb begin
    out_data = in_data;
    out_ctrl = in_ctrl;
    out_wr   = in_wr;
    in_rdy   = out_rdy;
    if (own_s) begin
      out_data = DATA_WIDTH'(probe_word_s);
      out_ctrl = CTRL_WIDTH'(probe_ctrl_s);
      out_wr   = out_rdy;
      in_rdy   = 1'b0;
    end else begin
      out_data = in_data;
      out_ctrl = in_ctrl;
      out_wr   = in_wr;
      in_rdy   = out_rdy;
    end
  end

  // State, configuration latches, counters and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      in_pkt_r     <= 1'b0;
      ts_r         <= '0;
      ts_last_r    <= '0;
      gap_cnt_r    <= 16'd0;
      seq_r        <= 16'd0;
      sent_count_r <= 16'd0;
      num_pkts_r   <= 16'd0;
      gap_r        <= 16'd0;
      dst_port_r   <= 8'h00;
      dst_ip_r     <= 32'h0;
      idx_r        <= 8'd0;
      busy_r       <= 1'b0;
      abort_pend_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      ts_r    <= ts_r + 1'b1;
      if (acc_pt_s && (in_ctrl == CTRL_WIDTH'(8'hff)))  in_pkt_r <= 1'b1;
      else if (acc_pt_s && (in_ctrl != CTRL_WIDTH'(0))) in_pkt_r <= 1'b0;
      if (start_s) begin
        num_pkts_r   <= cfg_num_pkts;
        gap_r        <= cfg_gap;
        dst_port_r   <= cfg_dst_port;
        dst_ip_r     <= cfg_dst_ip;
        sent_count_r <= 16'd0;
        seq_r        <= 16'd0;
        abort_pend_r <= 1'b0;
      end else if (own_s && abort_s) begin
        abort_pend_r <= 1'b1;
      end
      if (acc_own_s && (state_r == ST_HDR)) begin
        ts_last_r <= ts_r;
        gap_cnt_r <= 16'd1;
        idx_r     <= 8'd1;
      end else if (state_r != ST_IDLE) begin
        gap_cnt_r <= gap_nxt_s;
        if (acc_own_s) idx_r <= idx_r + 8'd1;
      end
      if (acc_own_s && last_word_s) begin
        sent_count_r <= sent_count_r + 16'd1;
        seq_r        <= seq_r + 16'd1;
      end
    end
  end

  assign busy       = busy_r;
  assign sent_count = sent_count_r;
  assign ts_last    = ts_last_r;

endmodule

// File: tb/tb_probe_train_gen.sv
// Directed bench for probe_train_gen: pass-through, trains, boundary wait, backpressure, short gap, reset.
module tb_probe_train_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic        in_wr, in_rdy, out_wr, out_rdy;
  logic        cfg_start;
  logic [15:0] cfg_num_pkts, cfg_gap, sent_count, ts_last;
  logic [7:0]  cfg_dst_port;
  logic [31:0] cfg_dst_ip;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] ts_m;
  logic [71:0] cap_q[$];
  logic [15:0] cap_ts[$];
  int          t_idle;

  probe_train_gen dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .cfg_start(cfg_start), .cfg_num_pkts(cfg_num_pkts), .cfg_gap(cfg_gap),
    .cfg_dst_port(cfg_dst_port), .cfg_dst_ip(cfg_dst_ip),
    .busy(busy), .sent_count(sent_count), .ts_last(ts_last)
  );

  always #5 clk = ~clk;

  // Reference timestamp: free-running, cleared by reset.
  always @(posedge clk) begin
    if (reset) ts_m <= 16'd0;
    else       ts_m <= ts_m + 16'd1;
  end

  // Record every accepted downstream word with its cycle stamp.
  always @(negedge clk) begin
    if (out_wr === 1'b1 && out_rdy === 1'b1) begin
      cap_q.push_back({out_ctrl, out_data});
      cap_ts.push_back(ts_m);
    end
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_cap();
    cap_q.delete();
    cap_ts.delete();
  endtask

  task automatic start_train(input logic [15:0] n, input logic [15:0] g,
                             input logic [7:0] port, input logic [31:0] ip);
    cfg_num_pkts = n; cfg_gap = g; cfg_dst_port = port; cfg_dst_ip = ip;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    t_idle = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        t_idle = int'(ts_m);
        break;
      end
    end
    check({tag, "_idle_in_time"}, {71'd0, t_idle >= 0}, 72'd1);
    step();
  endtask

  function automatic logic [71:0] probe_exp(input logic [7:0] port, input logic [31:0] ip,
                                            input logic [15:0] seq, input int w,
                                            input logic [15:0] hts);
    case (w)
      0:       return {8'hff, 8'h00, port, 16'h0007, 16'h0000, 16'h0038};
      1:       return {8'h00, ip, 16'h0800, seq};
      2:       return {8'h00, 48'h0, hts};
      7:       return {8'h01, seq, 16'h0, 24'h0, 8'h07};
      default: return {8'h00, seq, 16'h0, 24'h0, 8'(w)};
    endcase
  endfunction

  initial begin
    logic [7:0]  ctl_tab [6];
    logic [63:0] held;
    ctl_tab = '{8'hff, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    reset = 1'b1; in_data = 64'h0; in_ctrl = 8'h00; in_wr = 1'b0; out_rdy = 1'b1;
    cfg_start = 1'b0; cfg_num_pkts = 16'd0; cfg_gap = 16'd0; cfg_dst_port = 8'h00; cfg_dst_ip = 32'h0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("rst_busy", {71'd0, busy}, 72'd0);
    check("rst_sent", {56'd0, sent_count}, 72'd0);
    check("rst_ts_last", {56'd0, ts_last}, 72'd0);
    check("rst_out_wr", {71'd0, out_wr}, 72'd0);
    step();

    // 1: idle pass-through, same-cycle
    for (int i = 0; i < 5; i++) begin
      in_wr = 1'b1; in_ctrl = (i == 0) ? 8'hff : ((i == 4) ? 8'h01 : 8'h00);
      in_data = 64'h1111_0000_0000_0000 + 64'(i);
      #1;
      check($sformatf("pt_word%0d", i), {out_wr, in_rdy, out_ctrl, out_data[61:0]},
            {1'b1, 1'b1, in_ctrl, in_data[61:0]});
      step();
    end
    in_wr = 1'b0;
    check("pt_busy", {71'd0, busy}, 72'd0);

    // 2: basic train
    clear_cap();
    start_train(16'd3, 16'd20, 8'h04, 32'h0A00_0001);
    wait_idle("basic", 300);
    check("basic_nwords", 72'(cap_q.size()), 72'd24);
    if (cap_q.size() == 24) begin
      for (int p = 0; p < 3; p++)
        for (int w = 0; w < 8; w++)
          check($sformatf("basic_p%0d_w%0d", p, w), cap_q[p*8+w],
                probe_exp(8'h04, 32'h0A00_0001, 16'(p), w, cap_ts[p*8]));
      check("basic_delta1", {56'd0, 16'(cap_ts[8] - cap_ts[0])}, 72'd20);
      check("basic_delta2", {56'd0, 16'(cap_ts[16] - cap_ts[8])}, 72'd20);
      check("basic_ts_last", {56'd0, ts_last}, {56'd0, cap_ts[16]});
      check("basic_busy_fall", 72'(t_idle), 72'(int'(cap_ts[23]) + 1));
    end
    check("basic_sent", {56'd0, sent_count}, 72'd3);

    // 3: start while upstream is mid-packet
    clear_cap();
    for (int i = 0; i < 3; i++) begin
      in_wr = 1'b1; in_ctrl = ctl_tab[i]; in_data = 64'hB000_0000_0000_0000 + 64'(i);
      step();
    end
    in_wr = 1'b0;
    start_train(16'd1, 16'd5, 8'h02, 32'hC0A8_0001);
    repeat (5) step();
    check("bnd_busy_wait", {71'd0, busy}, 72'd1);
    check("bnd_no_hdr_yet", 72'(cap_q.size()), 72'd3);
    for (int i = 3; i < 6; i++) begin
      in_wr = 1'b1; in_ctrl = ctl_tab[i]; in_data = 64'hB000_0000_0000_0000 + 64'(i);
      step();
    end
    in_wr = 1'b0;
    wait_idle("bnd", 100);
    check("bnd_nwords", 72'(cap_q.size()), 72'd14);
    if (cap_q.size() == 14) begin
      check("bnd_up_eop", cap_q[5], {8'h01, 64'hB000_0000_0000_0005});
      check("bnd_hdr", cap_q[6], probe_exp(8'h02, 32'hC0A8_0001, 16'd0, 0, 16'd0));
      check("bnd_hdr_after_eop", {71'd0, cap_ts[6] > cap_ts[5]}, 72'd1);
      check("bnd_w1", cap_q[7], probe_exp(8'h02, 32'hC0A8_0001, 16'd0, 1, 16'd0));
      check("bnd_last", cap_q[13], probe_exp(8'h02, 32'hC0A8_0001, 16'd0, 7, 16'd0));
    end

    // 4: backpressure on word 3
    clear_cap();
    start_train(16'd1, 16'd5, 8'h01, 32'h0A00_00FF);
    for (int i = 0; i < 50; i++) begin
      if (cap_q.size() >= 3) break;
      step();
    end
    check("bp_reach_w3", 72'(cap_q.size()), 72'd3);
    out_rdy = 1'b0;
    #1;
    held = out_data;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("bp_hold%0d", i), {out_wr, out_data[63:0]}, {1'b0, 64'h0000_0000_0000_0003});
      step();
    end
    check("bp_held_first", {8'h00, held}, {8'h00, 64'h0000_0000_0000_0003});
    out_rdy = 1'b1;
    wait_idle("bp", 100);
    check("bp_nwords", 72'(cap_q.size()), 72'd8);
    if (cap_q.size() == 8) begin
      check("bp_w3", cap_q[3], probe_exp(8'h01, 32'h0A00_00FF, 16'd0, 3, 16'd0));
      check("bp_w4", cap_q[4], probe_exp(8'h01, 32'h0A00_00FF, 16'd0, 4, 16'd0));
      check("bp_last", cap_q[7], probe_exp(8'h01, 32'h0A00_00FF, 16'd0, 7, 16'd0));
    end

    // 5: short gap
    clear_cap();
    start_train(16'd2, 16'd2, 8'h08, 32'h0102_0304);
    wait_idle("gap", 200);
    check("gap_nwords", 72'(cap_q.size()), 72'd16);
    if (cap_q.size() == 16) begin
      check("gap_b2b", {56'd0, 16'(cap_ts[8] - cap_ts[7])}, 72'd1);
      check("gap_ts_delta", {56'd0, 16'(cap_ts[8] - cap_ts[0])}, 72'd8);
      check("gap_p1_w1", cap_q[9], probe_exp(8'h08, 32'h0102_0304, 16'd1, 1, 16'd0));
    end
    check("gap_sent", {56'd0, sent_count}, 72'd2);

    // 6a: zero-length train ignored
    clear_cap();
    start_train(16'd0, 16'd5, 8'h04, 32'h0A00_0001);
    repeat (5) step();
    check("zero_busy", {71'd0, busy}, 72'd0);
    check("zero_nwords", 72'(cap_q.size()), 72'd0);

    // 6b: reset in the middle of a probe
    clear_cap();
    start_train(16'd3, 16'd20, 8'h04, 32'h0A00_0001);
    for (int i = 0; i < 50; i++) begin
      if (cap_q.size() >= 3) break;
      step();
    end
    check("rstmid_in_body", {71'd0, busy}, 72'd1);
    reset = 1'b1;
    step();
    #1;
    check("rstmid_out_wr", {71'd0, out_wr}, 72'd0);
    check("rstmid_busy", {71'd0, busy}, 72'd0);
    check("rstmid_sent", {56'd0, sent_count}, 72'd0);
    reset = 1'b0;
    step();
    in_wr = 1'b1; in_ctrl = 8'hff; in_data = 64'hCAFE_0000_0000_0001;
    #1;
    check("rstmid_pt", {out_wr, in_rdy, out_ctrl, out_data[61:0]},
          {1'b1, 1'b1, 8'hff, 62'(64'hCAFE_0000_0000_0001)});
    step();
    in_ctrl = 8'h01; in_data = 64'hCAFE_0000_0000_0002;
    step();
    in_wr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
